traffic_phase_sequencer: RTL
============================

# traffic_phase_sequencer

Clocked scheduler that drives the seven-phase traffic-light sequence (phases 0–6) from a slow tick. It owns all phase timing and replaces free-running per-phase counters. It latches pedestrian requests, stretches the main-road green when nobody is waiting, and freezes on an emergency hold. It issues a one-cycle `advance` strobe at each phase change, so downstream light, walk and buzzer decode can run on `clk`.

## Interface
- `T1_MIN`, 30: minimum main-green duration (phase 0), in ticks.
- `T1_MAX`, 60: maximum main-green duration when no pedestrian request is pending, in ticks; must be ≥ `T1_MIN`.
- `T2`, 5: duration of phases 1, 2, 4 and 6, in ticks.
- `T3`, 15: duration of phases 3 and 5, in ticks.
- `CW`, 8: width of the countdown counter. All durations are ≥ 1, and `T1_MAX`, `T2`, `T3` ≤ 2^CW.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `tick` in 1: single-cycle timebase enable (e.g. 1 Hz strobe).
- `ped_req` in 1: pedestrian button, level, already synchronised to `clk`.
- `hold` in 1: emergency freeze, level.
- `phase` out 4: current phase, 0–6.
- `enable` out 3: one-hot timer class. Bit 0 = phase 0; bit 1 = phases 1, 2, 4, 6; bit 2 = phases 3, 5.
- `advance` out 1: one-cycle pulse in the cycle `phase` takes its new value.
- `remaining` out CW: ticks left in the current phase, minus 1.
- `ped_pending` out 1: latched pedestrian request.
- `extended` out 1: high while phase 0 is in its extension window.
- `walk` out 1: high when `phase` == 3.

## Operation
- **Reset values:** `phase`=0, `remaining`=`T1_MIN`-1, `advance`=0, `ped_pending`=0, `extended`=0, `enable`=3'b001, `walk`=0.
- **Counting:** an effective tick is `tick` & !`hold`. On an effective tick, if `remaining`≠0 the counter decrements; otherwise the phase expires.
- **Expiry in phases 1–6:** `phase` ← (`phase`+1), with 6 wrapping to 0. `remaining` ← new phase duration − 1. `advance`=1 for that cycle.
- **Phase 0, minimum window** (`extended`=0), on expiry:
  - if `ped_pending`=1 or `T1_MAX`=`T1_MIN`: advance to phase 1;
  - otherwise: `extended` ← 1, `remaining` ← `T1_MAX`-`T1_MIN`-1, no advance.
- **Phase 0, extension window** (`extended`=1): advance to phase 1 on the first effective tick where `ped_pending`=1 or the counter expires. `extended` clears on any advance.
- **Entering phase 0:** `remaining` loads `T1_MIN`-1.
- **ped_pending:**
  - set on any cycle with `ped_req`=1 while `phase`≠3;
  - cleared in the cycle phase 3 is entered; clear wins over a simultaneous `ped_req`;
  - `ped_req` is ignored throughout phase 3.
- **hold:** freezes `remaining`, `phase` and `extended`, and forces `advance`=0. `ped_pending` still latches during hold.
- **Unreachable phase values 7–15:** recover to phase 0 on the next clock with the phase-0 reload; `enable`=3'b000 while there.
- `enable` and `walk` are decoded combinationally from `phase`.

## Timing
- `tick`→state latency: one clock. The register update and the `advance` pulse happen on the edge that samples the expiring tick.
- `advance` is never high for two consecutive cycles, even with `tick` held high continuously.
- **Phase lengths in effective ticks:**
  - phase 0: `T1_MIN` if a request is pending at minimum expiry, else up to `T1_MAX`;
  - phases 1, 2, 4, 6: `T2`;
  - phases 3, 5: `T3`.
- Full cycle with no requests = `T1_MAX` + 4·`T2` + 2·`T3` ticks.
- `reset` asserted mid-phase returns all outputs to reset values immediately (asynchronously). The first effective tick after deassertion counts as the first tick of phase 0.
- A `tick` coinciding with `reset` deassertion is ignored if `reset` is still high at the edge.

## Test plan
Test parameters for all scenarios: `T1_MIN`=3, `T1_MAX`=6, `T2`=2, `T3`=4, `CW`=4.
- **Reset values:** assert reset, then release. Expect `phase`=0, `remaining`=2, `enable`=001, `advance`=0, `ped_pending`=0.
- **No requests, continuous ticks:** phase 0 lasts 6 ticks, with `extended`=1 from tick 3. The observed sequence is 0,1,2,3,4,5,6,0, with 7 `advance` pulses over 22 ticks.
- **Early exit on request:** pulse `ped_req` before the 3rd tick. Phase 0 ends after exactly 3 ticks. `ped_pending` clears on entry to phase 3, and `walk`=1 for 4 ticks.
- **Request during extension:** pulse `ped_req` after tick 4 of phase 0. `advance` fires on tick 5.
- **Hold:** assert `hold` for 10 ticks in phase 3 with `remaining`=2. `phase` and `remaining` stay unchanged and no `advance` occurs. After release, phase 4 starts 3 ticks later.
- **Clear priority and reset mid-operation:** drive `ped_req`=1 in the phase-3 entry cycle; expect `ped_pending`=0 afterward. Then assert `reset` in phase 5; expect reset values the same cycle.

Source files
------------

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the traffic phase sequencer and its environment.
// The slave modport is the sequencer; the master modport drives tick/request/hold.
interface traffic_phase_sequencer_if #(
    parameter int CW = 8
) ();
    logic          tick;
    logic          ped_req;
    logic          hold;
    logic [3:0]    phase;
    logic [2:0]    enable;
    logic          advance;
    logic [CW-1:0] remaining;
    logic          ped_pending;
    logic          extended;
    logic          walk;

    modport master (
        output tick, ped_req, hold,
        input  phase, enable, advance, remaining, ped_pending, extended, walk
    );

    modport slave (
        input  tick, ped_req, hold,
        output phase, enable, advance, remaining, ped_pending, extended, walk
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Seven-phase traffic-light scheduler driven by a slow tick, with pedestrian
// latching, main-green extension, emergency hold and a one-cycle advance strobe.
module traffic_phase_sequencer #(
    parameter int T1_MIN = 30,
    parameter int T1_MAX = 60,
    parameter int T2     = 5,
    parameter int T3     = 15,
    parameter int CW     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_sequencer_if.slave    bus
);

    typedef enum logic [3:0] {
        PH0 = 4'd0, PH1 = 4'd1, PH2 = 4'd2, PH3 = 4'd3,
        PH4 = 4'd4, PH5 = 4'd5, PH6 = 4'd6
    } phase_t;

    localparam logic [CW-1:0] L_T1_MIN = CW'(T1_MIN - 1);
    localparam logic [CW-1:0] L_EXT    = CW'(T1_MAX - T1_MIN - 1);
    localparam logic [CW-1:0] L_T2     = CW'(T2 - 1);
    localparam logic [CW-1:0] L_T3     = CW'(T3 - 1);
    localparam bit            NO_EXT   = (T1_MAX == T1_MIN);

    phase_t        r_phase, w_phase_nxt;
    logic [CW-1:0] r_remaining, w_rem_nxt;
    logic          r_extended, w_ext_nxt;
    logic          r_advance, w_adv_nxt;
    logic          r_ped_pending, w_pend_nxt;
    logic          w_eff_tick;
    logic          w_go;
    logic          w_rem_zero;

    function automatic logic [CW-1:0] f_reload(input phase_t p);
        case (p)
            PH0:      f_reload = L_T1_MIN;
            PH3, PH5: f_reload = L_T3;
            default:  f_reload = L_T2;
        endcase
    endfunction

    assign w_rem_zero = (r_remaining == '0);
    // A tick landing in an advance cycle with a zero reload is absorbed so
    // advance can never pulse on back-to-back cycles.
    assign w_eff_tick = bus.tick & ~bus.hold & ~(r_advance & w_rem_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase       <= PH0;
            r_remaining   <= L_T1_MIN;
            r_extended    <= 1'b0;
            r_advance     <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_remaining   <= w_rem_nxt;
            r_extended    <= w_ext_nxt;
            r_advance     <= w_adv_nxt;
            r_ped_pending <= w_pend_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_rem_nxt   = r_remaining;
        w_ext_nxt   = r_extended;
        w_adv_nxt   = 1'b0;
        w_go        = 1'b0;

        case (r_phase)
            PH0: begin
                if (w_eff_tick) begin
                    if (r_extended) begin
                        if (r_ped_pending || w_rem_zero) w_go = 1'b1;
                        else                             w_rem_nxt = r_remaining - CW'(1);
                    end else if (!w_rem_zero) begin
                        w_rem_nxt = r_remaining - CW'(1);
                    end else if (r_ped_pending || NO_EXT) begin
                        w_go = 1'b1;
                    end else begin
                        w_ext_nxt = 1'b1;
                        w_rem_nxt = L_EXT;
                    end
                end
            end
            PH1, PH2, PH3, PH4, PH5, PH6: begin
                if (w_eff_tick) begin
                    if (!w_rem_zero) w_rem_nxt = r_remaining - CW'(1);
                    else             w_go = 1'b1;
                end
            end
            default: begin
                w_phase_nxt = PH0;
                w_rem_nxt   = L_T1_MIN;
                w_ext_nxt   = 1'b0;
            end
        endcase

        if (w_go) begin
            w_phase_nxt = (r_phase == PH6) ? PH0 : phase_t'(r_phase + 4'd1);
            w_rem_nxt   = f_reload(w_phase_nxt);
            w_ext_nxt   = 1'b0;
            w_adv_nxt   = 1'b1;
        end
    end

    // Entering the walk phase clears the request and wins over a new press.
    always_comb begin
        w_pend_nxt = r_ped_pending;
        if (w_phase_nxt == PH3 && r_phase != PH3) w_pend_nxt = 1'b0;
        else if (r_phase != PH3 && bus.ped_req)   w_pend_nxt = 1'b1;
    end

    always_comb begin
        bus.enable = 3'b000;
        case (r_phase)
            PH0:                bus.enable = 3'b001;
            PH1, PH2, PH4, PH6: bus.enable = 3'b010;
            PH3, PH5:           bus.enable = 3'b100;
            default:            bus.enable = 3'b000;
        endcase
    end

    assign bus.phase       = r_phase;
    assign bus.remaining   = r_remaining;
    assign bus.extended    = r_extended;
    assign bus.advance     = r_advance;
    assign bus.ped_pending = r_ped_pending;
    assign bus.walk        = (r_phase == PH3);

endmodule
